// File: rtl/xheep_exit_reporter_pkg.sv
// Shared types and constants for the exit-status reporter: FSM states, the fixed
// "EXIT:" prefix / line terminator bytes, and the nibble-to-hex-ASCII helper.
package xheep_exit_reporter_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  localparam int unsigned MSG_LEN = 15;

  localparam logic [7:0] CHAR_E     = 8'h45;
  localparam logic [7:0] CHAR_X     = 8'h58;
  localparam logic [7:0] CHAR_I     = 8'h49;
  localparam logic [7:0] CHAR_T     = 8'h54;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h41 + ({4'h0, nib} - 8'd10);
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first, registered output. Accepts a new byte in the
// last stop-bit cycle so consecutive characters go out back-to-back.
module uart_tx_8n1 #(
  parameter int unsigned BAUD_DIV = 130
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baud_end;

  assign baud_end = (baud_q == 16'(BAUD_DIV - 1));
  assign ready_o  = (state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_end);
  assign tx_o     = tx_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (valid_i) begin
          state_d = TX_START;
          shift_d = data_i;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (baud_end) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          if (valid_i) begin
            state_d = TX_START;
            shift_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/xheep_exit_status_reporter.sv
// Captures the program exit code on each exit_valid rise, prints "EXIT:XXXXXXXX\r\n"
// on a debug UART and drives pass/fail LEDs once the line has been sent.
module xheep_exit_status_reporter
  import xheep_exit_reporter_pkg::*;
#(
  parameter int unsigned BAUD_DIV           = 130,
  parameter int unsigned BLINK_COUNT_LENGTH = 23
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_led_o,
  output logic        fail_led_o
);

  state_e                        state_q, state_d;
  logic                          prev_valid_q;
  logic [31:0]                   code_q, code_d;
  logic [3:0]                    idx_q, idx_d;
  logic [BLINK_COUNT_LENGTH-1:0] cnt_q;
  logic                          rise, start;
  logic                          tx_valid, tx_ready;
  logic [7:0]                    tx_data, cur_char;
  logic [2:0]                    nib_sel;

  assign rise  = exit_valid_i && !prev_valid_q;
  assign start = rise && (state_q != SEND);

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      code_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= exit_valid_i;
      code_q       <= code_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_q + 1'b1;
    end
  end

  // idx 5..12 select code nibbles 7..0 (MSB first)
  assign nib_sel = 3'(4'd12 - idx_q);

  always_comb begin
    cur_char = nibble_to_ascii(code_q[{nib_sel, 2'b00} +: 4]);
    case (idx_q)
      4'd0:    cur_char = CHAR_E;
      4'd1:    cur_char = CHAR_X;
      4'd2:    cur_char = CHAR_I;
      4'd3:    cur_char = CHAR_T;
      4'd4:    cur_char = CHAR_COLON;
      4'd13:   cur_char = CHAR_CR;
      4'd14:   cur_char = CHAR_LF;
      default: ;
    endcase
  end

  // Character 0 is handed over in the rise cycle itself so the start bit appears
  // one cycle later; the index therefore resumes at 1.
  assign tx_valid = start || ((state_q == SEND) && (idx_q < 4'(MSG_LEN)));
  assign tx_data  = start ? CHAR_E : cur_char;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEND;
          code_d  = exit_value_i;
          idx_d   = 4'd1;
        end
      end
      SEND: begin
        // With every character queued, ready marks the last stop-bit cycle.
        if (idx_q == 4'(MSG_LEN)) begin
          if (tx_ready) state_d = DONE;
        end else if (tx_ready) begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == SEND);
    done_o     = (state_q == DONE);
    pass_led_o = done_o && (code_q == '0);
    fail_led_o = done_o && (code_q != '0) && cnt_q[BLINK_COUNT_LENGTH-1];
  end

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .data_i (tx_data),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .tx_o   (uart_tx_o)
  );

endmodule

// File: tb/tb_xheep_exit_status_reporter.sv
// Bench for xheep_exit_status_reporter: table of report vectors checked through a
// UART-decoding scoreboard, plus hand sequences for reset and ignored rises.
module tb_xheep_exit_status_reporter;

  localparam int unsigned BD = 4;
  localparam int unsigned BL = 4;

  logic        clk_gen = 1'b0;
  logic        rst_n;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        uart_tx_o, busy_o, done_o, pass_led_o, fail_led_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] code;
    bit          exp_pass;
    int          interfere;
  } vec_t;

  vec_t vecs[4];

  xheep_exit_status_reporter #(
    .BAUD_DIV          (BD),
    .BLINK_COUNT_LENGTH(BL)
  ) dut (
    .clk_gen     (clk_gen),
    .rst_n       (rst_n),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .uart_tx_o   (uart_tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_led_o  (pass_led_o),
    .fail_led_o  (fail_led_o)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_line(input logic [31:0] code);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h49);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h3A);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_char(code[4*i +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART decoder: samples each bit in its centre and pops the scoreboard per byte.
  int         mon_cnt    = 0;
  bit         mon_active = 1'b0;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  always @(negedge clk_gen) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else if (!mon_active) begin
      if (uart_tx_o == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) check("rx_start_bit", 32'(uart_tx_o), 32'd0);
      if ((mon_cnt >= 6) && (mon_cnt <= 34) && ((mon_cnt % 4) == 2))
        mon_byte[(mon_cnt - 6) / 4] = uart_tx_o;
      if (mon_cnt == 38) begin
        check("rx_stop_bit", 32'(uart_tx_o), 32'd1);
        if (exp_q.size() == 0) begin
          check("rx_unexpected_byte", 32'(mon_byte), 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_byte", 32'(mon_byte), 32'(mon_exp));
        end
      end
      if (mon_cnt == 39) mon_active = 1'b0;
    end
  end

  task automatic run_report(input logic [31:0] code, input bit exp_pass, input int interfere);
    int   n;
    int   toggles, fail_hi, pass_hi, extra_busy;
    logic prev_fail;
    logic tx_log[64];
    @(negedge clk_gen);
    exit_valid_i = 1'b1;
    exit_value_i = code;
    push_line(code);
    @(negedge clk_gen);
    check("busy_after_rise", 32'(busy_o), 32'd1);
    check("done_cleared", 32'(done_o), 32'd0);
    exit_valid_i = 1'b0;
    n = 0;
    while (busy_o && (n < 1000)) begin
      if (n < 64) tx_log[n] = uart_tx_o;
      if (n == interfere) begin
        exit_valid_i = 1'b1;
        exit_value_i = 32'h1;
      end
      @(negedge clk_gen);
      n++;
    end
    check("busy_cycles", 32'(n), 32'(150 * BD));
    check("tx_start_first", 32'(tx_log[0]), 32'd0);
    check("tx_start_last", 32'(tx_log[BD-1]), 32'd0);
    check("tx_first_data", 32'(tx_log[BD]), 32'd1);
    check("tx_char0_stop", 32'(tx_log[10*BD-1]), 32'd1);
    check("tx_no_gap", 32'(tx_log[10*BD]), 32'd0);
    check("done_set", 32'(done_o), 32'd1);
    check("rx_all_bytes", 32'(exp_q.size()), 32'd0);
    toggles = 0; fail_hi = 0; pass_hi = 0;
    prev_fail = fail_led_o;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) begin
        fail_hi += int'(fail_led_o);
        pass_hi += int'(pass_led_o);
      end
      if (i > 0 && fail_led_o != prev_fail) toggles++;
      prev_fail = fail_led_o;
      @(negedge clk_gen);
    end
    check("pass_led_on", 32'(pass_hi), exp_pass ? 32'd32 : 32'd0);
    check("fail_led_high", 32'(fail_hi), exp_pass ? 32'd0 : 32'(1 << (BL - 1)) * 2);
    check("fail_led_toggles", 32'(toggles), exp_pass ? 32'd0 : 32'd4);
    if (interfere >= 0) begin
      extra_busy = 0;
      for (int i = 0; i < 50; i++) begin
        extra_busy += int'(busy_o);
        @(negedge clk_gen);
      end
      check("held_valid_no_report", 32'(extra_busy), 32'd0);
      check("held_valid_done", 32'(done_o), 32'd1);
      exit_valid_i = 1'b0;
      @(negedge clk_gen);
    end
  endtask

  initial begin
    vecs[0] = '{code: 32'h0000_0000, exp_pass: 1'b1, interfere: -1};
    vecs[1] = '{code: 32'hCAFE_F00D, exp_pass: 1'b0, interfere: 100};
    vecs[2] = '{code: 32'hDEAD_BEEF, exp_pass: 1'b0, interfere: -1};
    vecs[3] = '{code: 32'h0000_0000, exp_pass: 1'b1, interfere: -1};

    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    repeat (3) @(negedge clk_gen);
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_leds", {30'd0, pass_led_o, fail_led_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_gen);

    foreach (vecs[v]) run_report(vecs[v].code, vecs[v].exp_pass, vecs[v].interfere);

    // Reset in the middle of the second character, then a clean report.
    @(negedge clk_gen);
    exit_valid_i = 1'b1;
    exit_value_i = 32'h1234_5678;
    push_line(32'h1234_5678);
    @(negedge clk_gen);
    exit_valid_i = 1'b0;
    repeat (57) @(negedge clk_gen);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(uart_tx_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_leds", {30'd0, pass_led_o, fail_led_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_gen);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_gen);
    run_report(32'h0000_000A, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
